// File: rtl/fifo_sram_writer_if.sv
// Bus bundle between the FIFO read port, fifo_sram_writer and the SRAM pins.
// With SRAM_VERIFY_EN defined the SRAM read-back path sram_dq_in is added.
interface fifo_sram_writer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 18
);
   // FIFO side: fifo_rd_en is a one-clock pop that is only raised while fifo_empty=0,
   // so the FIFO always accepts it; the popped word appears on fifo_data one clock later.
   logic [DATA_W-1:0] fifo_data;
   logic              fifo_empty;
   logic              fifo_rd_en;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_dq_out;
   logic              sram_dq_oe;
   logic              sram_ce_n;
   logic              sram_we_n;
   logic              sram_oe_n;
`ifdef SRAM_VERIFY_EN
   logic [DATA_W-1:0] sram_dq_in;
`endif

   modport master (
      input  fifo_data, fifo_empty,
`ifdef SRAM_VERIFY_EN
      input  sram_dq_in,
`endif
      output fifo_rd_en, sram_addr, sram_dq_out, sram_dq_oe,
      output sram_ce_n, sram_we_n, sram_oe_n
   );

   modport slave (
      output fifo_data, fifo_empty,
`ifdef SRAM_VERIFY_EN
      output sram_dq_in,
`endif
      input  fifo_rd_en, sram_addr, sram_dq_out, sram_dq_oe,
      input  sram_ce_n, sram_we_n, sram_oe_n
   );
endinterface

// File: rtl/fifo_sram_writer.sv
// Drains a 16-bit FIFO into asynchronous SRAM with timed ce_n/we_n/oe_n strobes.
// Define SRAM_VERIFY_EN to add a read-back VERIFY state and the verify_err flag.
module fifo_sram_writer #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 18,
   parameter int WE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   fifo_sram_writer_if.master bus,
   output logic              busy,
   output logic [15:0]       words_written,
   output logic              addr_wrap,
`ifdef SRAM_VERIFY_EN
   output logic              verify_err,
`endif
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_POP,
      S_LATCH,
      S_SETUP,
      S_WRITE,
      S_HOLD
`ifdef SRAM_VERIFY_EN
      , S_VERIFY
`endif
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [15:0]       words_q, words_d;
   logic              wrap_q, wrap_d;
   logic              rd_en_q, rd_en_d;
   logic              dq_oe_q, dq_oe_d;
   logic              ce_n_q, ce_n_d;
   logic              we_n_q, we_n_d;
   logic              oe_n_q, oe_n_d;
   logic              busy_q, busy_d;
   logic              pop_ok;
   logic              word_done;
`ifdef SRAM_VERIFY_EN
   logic              verr_q, verr_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         words_q <= '0;
         wrap_q  <= 1'b0;
         rd_en_q <= 1'b0;
         dq_oe_q <= 1'b0;
         ce_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         busy_q  <= 1'b0;
`ifdef SRAM_VERIFY_EN
         verr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         words_q <= words_d;
         wrap_q  <= wrap_d;
         rd_en_q <= rd_en_d;
         dq_oe_q <= dq_oe_d;
         ce_n_q  <= ce_n_d;
         we_n_q  <= we_n_d;
         oe_n_q  <= oe_n_d;
         busy_q  <= busy_d;
`ifdef SRAM_VERIFY_EN
         verr_q  <= verr_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      data_d    = data_q;
      words_d   = words_q;
      wrap_d    = 1'b0;
      word_done = 1'b0;
      pop_ok    = enable && !bus.fifo_empty;
`ifdef SRAM_VERIFY_EN
      verr_d    = verr_q;
`endif

      case (state_q)
         S_IDLE: begin
            // The load happens in the same clock as a pop decision, so word 0 lands on base_addr.
            if (start) begin
               addr_d  = base_addr;
               words_d = '0;
`ifdef SRAM_VERIFY_EN
               verr_d  = 1'b0;
`endif
            end
            if (pop_ok) state_d = S_POP;
         end
         S_POP:   state_d = S_LATCH;
         S_LATCH: begin
            data_d  = bus.fifo_data;
            state_d = S_SETUP;
         end
         S_SETUP: begin
            cnt_d   = '0;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            if (cnt_q == 4'(WE_CYCLES - 1)) state_d = S_HOLD;
            else                            cnt_d   = cnt_q + 4'd1;
         end
`ifdef SRAM_VERIFY_EN
         S_HOLD: begin
            cnt_d   = '0;
            state_d = S_VERIFY;
         end
         S_VERIFY: begin
            if (cnt_q == 4'd1) begin
               if (bus.sram_dq_in != data_q) verr_d = 1'b1;
               word_done = 1'b1;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
`else
         S_HOLD:  word_done = 1'b1;
`endif
         default: state_d = S_IDLE;
      endcase

      // End of a word: advance pointer and count, then chain straight into the next pop if possible.
      if (word_done) begin
         addr_d  = addr_q + 1'b1;
         words_d = words_q + 16'd1;
         wrap_d  = &addr_q;
         state_d = pop_ok ? S_POP : S_IDLE;
      end

      // Strobes are registered from the next state so they line up with state_q.
      rd_en_d = (state_d == S_POP);
      dq_oe_d = state_d inside {S_SETUP, S_WRITE, S_HOLD};
      ce_n_d  = !(state_d inside {S_SETUP, S_WRITE, S_HOLD});
      we_n_d  = (state_d != S_WRITE);
      busy_d  = (state_d != S_IDLE);
`ifdef SRAM_VERIFY_EN
      if (state_d == S_VERIFY) ce_n_d = 1'b0;
      oe_n_d  = (state_d != S_VERIFY);
`else
      oe_n_d  = 1'b1;
`endif
   end

   assign bus.fifo_rd_en  = rd_en_q;
   assign bus.sram_addr   = addr_q;
   assign bus.sram_dq_out = data_q;
   assign bus.sram_dq_oe  = dq_oe_q;
   assign bus.sram_ce_n   = ce_n_q;
   assign bus.sram_we_n   = we_n_q;
   assign bus.sram_oe_n   = oe_n_q;
   assign busy            = busy_q;
   assign words_written   = words_q;
   assign addr_wrap       = wrap_q;
   assign dbg_state       = state_q;
`ifdef SRAM_VERIFY_EN
   assign verify_err      = verr_q;
`endif

endmodule

// File: tb/tb_fifo_sram_writer.sv
// Bench for fifo_sram_writer: FIFO model, SRAM write monitor, vector table,
// corner-case sequences and randomized rounds against a queue-based model.
`timescale 1ns/1ps
module tb_fifo_sram_writer;
   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 18;
   localparam int WE_CYCLES = 2;
   localparam int ADDR_SPAN = 262144;
`ifdef SRAM_VERIFY_EN
   localparam int PER_WORD    = 6 + WE_CYCLES;
   localparam int CE_PER_WORD = 4 + WE_CYCLES;
`else
   localparam int PER_WORD    = 4 + WE_CYCLES;
   localparam int CE_PER_WORD = 2 + WE_CYCLES;
`endif

   typedef struct {
      logic [17:0] base;
      int          n;
      logic [15:0] d0;
      logic [17:0] exp_addr;
      int          exp_wraps;
      int          exp_wrap_word;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic [17:0] base_addr = '0;
   logic        busy;
   logic [15:0] words_written;
   logic        addr_wrap;
   logic [2:0]  dbg_state;
`ifdef SRAM_VERIFY_EN
   logic        verify_err;
`endif

   always #5 clk = ~clk;

   fifo_sram_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   fifo_sram_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WE_CYCLES(WE_CYCLES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .start         (start),
      .base_addr     (base_addr),
      .bus           (bus),
      .busy          (busy),
      .words_written (words_written),
      .addr_wrap     (addr_wrap),
`ifdef SRAM_VERIFY_EN
      .verify_err    (verify_err),
`endif
      .dbg_state     (dbg_state)
   );

   // ---------------- FIFO model ----------------
   logic [15:0] fifo_mem [0:1023];
   int          push_cnt = 0;
   int          pop_cnt = 0;
   int          underflow = 0;
   logic [15:0] fifo_data_q = '0;

   assign bus.fifo_empty = (push_cnt == pop_cnt);
   assign bus.fifo_data  = fifo_data_q;

   always @(posedge clk) begin
      if (bus.fifo_rd_en) begin
         if (push_cnt == pop_cnt) underflow <= underflow + 1;
         else begin
            fifo_data_q <= fifo_mem[pop_cnt % 1024];
            pop_cnt     <= pop_cnt + 1;
         end
      end
   end

   // ---------------- SRAM monitor ----------------
   logic [17:0] act_addr [0:1023];
   logic [15:0] act_data [0:1023];
   int          act_n = 0;
   int          rd_pulses = 0, busy_cyc = 0, ce_cyc = 0, wrap_cnt = 0, wrap_word = 0, viol = 0;
   logic        prev_we_n = 1'b1;
   logic [17:0] wr_addr = '0;
   logic [15:0] wr_data = '0;
`ifdef SRAM_VERIFY_EN
   logic [15:0] sram_mem [0:255];
   logic [17:0] corrupt_addr = 18'h2AAAA;
   assign bus.sram_dq_in = sram_mem[bus.sram_addr[7:0]] ^
                           ((bus.sram_addr == corrupt_addr) ? 16'h0001 : 16'h0000);
`endif

   always @(negedge clk) begin
      if (bus.fifo_rd_en) rd_pulses = rd_pulses + 1;
      if (busy) busy_cyc = busy_cyc + 1;
      if (!bus.sram_ce_n) ce_cyc = ce_cyc + 1;
      if (addr_wrap) begin
         wrap_cnt  = wrap_cnt + 1;
         wrap_word = int'(words_written);
      end
      if (!bus.sram_we_n) begin
         if (prev_we_n) begin
            wr_addr = bus.sram_addr;
            wr_data = bus.sram_dq_out;
            act_addr[act_n % 1024] = wr_addr;
            act_data[act_n % 1024] = wr_data;
            act_n = act_n + 1;
`ifdef SRAM_VERIFY_EN
            sram_mem[wr_addr[7:0]] = wr_data;
`endif
         end else if (bus.sram_addr != wr_addr || bus.sram_dq_out != wr_data) begin
            viol = viol + 1;
         end
         if (bus.sram_ce_n || !bus.sram_dq_oe || !bus.sram_oe_n) viol = viol + 1;
      end
`ifdef SRAM_VERIFY_EN
      if (!bus.sram_oe_n && (bus.sram_ce_n || bus.sram_dq_oe)) viol = viol + 1;
`else
      if (!bus.sram_oe_n) viol = viol + 1;
`endif
      prev_we_n = bus.sram_we_n;
   end

   // ---------------- scoreboard ----------------
   logic [33:0] exp_q[$];
   int          act_idx = 0;
   int          total = 0;
   int          bad = 0;
   int          s_rd, s_busy, s_ce, s_wrap, s_viol, s_under;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] d);
      fifo_mem[push_cnt % 1024] = d;
      push_cnt = push_cnt + 1;
   endtask

   task automatic snap();
      s_rd    = rd_pulses;
      s_busy  = busy_cyc;
      s_ce    = ce_cyc;
      s_wrap  = wrap_cnt;
      s_viol  = viol;
      s_under = underflow;
   endtask

   task automatic compare_writes();
      logic [33:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (act_idx < act_n) begin
            check("sram_write", 64'({act_addr[act_idx % 1024], act_data[act_idx % 1024]}), 64'(e));
            act_idx = act_idx + 1;
         end else begin
            check("sram_write_missing", 64'(act_n), 64'(act_idx + 1));
         end
      end
      check("write_count", 64'(act_n), 64'(act_idx));
   endtask

   task automatic check_counts(input int n);
      check("rd_pulses", 64'(rd_pulses - s_rd), 64'(n));
      check("busy_cycles", 64'(busy_cyc - s_busy), 64'(n * PER_WORD));
      check("ce_cycles", 64'(ce_cyc - s_ce), 64'(n * CE_PER_WORD));
      check("strobe_rules", 64'(viol - s_viol), 64'(0));
      check("fifo_underflow", 64'(underflow - s_under), 64'(0));
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      repeat (3) @(negedge clk);
      while (busy && k < budget) begin
         @(negedge clk);
         k = k + 1;
      end
      check("idle_timeout", 64'(busy), 64'(0));
   endtask

   task automatic wait_word2_write(input int budget);
      int k;
      k = 0;
      while (!(words_written == 16'd1 && !bus.sram_we_n) && k < budget) begin
         @(negedge clk);
         k = k + 1;
      end
      check("reach_word2_write", 64'(k < budget), 64'(1));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t        vecs[5];
      int          n, pushed, base_i, k;
      logic [15:0] d;

      vecs[0] = '{18'h00100, 16, 16'h0100, 18'h00110, 0, 0};
      vecs[1] = '{18'h01234,  0, 16'h0000, 18'h01234, 0, 0};
      vecs[2] = '{18'h3FFFE,  3, 16'h5500, 18'h00001, 1, 2};
      vecs[3] = '{18'h3FFFF,  1, 16'h7777, 18'h00000, 1, 1};
      vecs[4] = '{18'h00000,  4, 16'hBEEF, 18'h00004, 0, 0};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rd_en", 64'(bus.fifo_rd_en), 64'(0));
      check("rst_addr", 64'(bus.sram_addr), 64'(0));
      check("rst_dq_out", 64'(bus.sram_dq_out), 64'(0));
      check("rst_dq_oe", 64'(bus.sram_dq_oe), 64'(0));
      check("rst_ce_n", 64'(bus.sram_ce_n), 64'(1));
      check("rst_we_n", 64'(bus.sram_we_n), 64'(1));
      check("rst_oe_n", 64'(bus.sram_oe_n), 64'(1));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_words", 64'(words_written), 64'(0));
      check("rst_wrap", 64'(addr_wrap), 64'(0));
      check("rst_state", 64'(dbg_state), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table: preload, start coincident with enable, drain, compare.
      for (int i = 0; i < 5; i++) begin
         snap();
         for (int j = 0; j < vecs[i].n; j++) begin
            push_word(vecs[i].d0 + 16'(j));
            exp_q.push_back({18'(vecs[i].base + 18'(j)), 16'(vecs[i].d0 + 16'(j))});
         end
         base_addr = vecs[i].base;
         start = 1'b1;
         enable = 1'b1;
         @(negedge clk);
         start = 1'b0;
         wait_idle(2000);
         repeat (20) @(negedge clk);
         enable = 1'b0;
         compare_writes();
         check("vec_words", 64'(words_written), 64'(vecs[i].n));
         check("vec_addr", 64'(bus.sram_addr), 64'(vecs[i].exp_addr));
         check("vec_wraps", 64'(wrap_cnt - s_wrap), 64'(vecs[i].exp_wraps));
         if (vecs[i].exp_wraps > 0) check("vec_wrap_word", 64'(wrap_word), 64'(vecs[i].exp_wrap_word));
         check_counts(vecs[i].n);
      end

      // Enable drops during word 2's write; a start while busy must be ignored.
      snap();
      for (int j = 0; j < 5; j++) begin
         push_word(16'hA000 + 16'(j));
         exp_q.push_back({18'h00200 + 18'(j), 16'hA000 + 16'(j)});
      end
      base_addr = 18'h00200;
      start = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_word2_write(200);
      enable = 1'b0;
      base_addr = 18'h03000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle(200);
      check("drop_words", 64'(words_written), 64'(2));
      check("drop_fifo_left", 64'(push_cnt - pop_cnt), 64'(3));
      check("drop_addr", 64'(bus.sram_addr), 64'(18'h00202));
      enable = 1'b1;
      wait_idle(500);
      enable = 1'b0;
      check("resume_words", 64'(words_written), 64'(5));
      check("resume_addr", 64'(bus.sram_addr), 64'(18'h00205));
      compare_writes();
      check_counts(5);

      // Asynchronous reset in the middle of a write pulse.
      for (int j = 0; j < 2; j++) begin
         push_word(16'hC0DE + 16'(j));
         exp_q.push_back({18'h00040 + 18'(j), 16'hC0DE + 16'(j)});
      end
      base_addr = 18'h00040;
      start = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_word2_write(200);
      #2 rst_n = 1'b0;
      #1;
      check("arst_we_n", 64'(bus.sram_we_n), 64'(1));
      check("arst_ce_n", 64'(bus.sram_ce_n), 64'(1));
      check("arst_dq_oe", 64'(bus.sram_dq_oe), 64'(0));
      check("arst_words", 64'(words_written), 64'(0));
      check("arst_busy", 64'(busy), 64'(0));
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      compare_writes();
      check("arst_fifo_left", 64'(push_cnt - pop_cnt), 64'(0));

      // Randomized rounds: random base, trickled pushes, random enable gaps.
      for (int r = 0; r < 12; r++) begin
         if ($urandom_range(0, 3) == 0) base_i = ADDR_SPAN - int'($urandom_range(1, 4));
         else                           base_i = int'($urandom_range(0, ADDR_SPAN - 1));
         n = int'($urandom_range(1, 10));
         snap();
         base_addr = 18'(base_i);
         enable = 1'b0;
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         pushed = 0;
         k = 0;
         while (pushed < n && k < 1000) begin
            if ($urandom_range(0, 2) == 0) begin
               d = 16'($urandom);
               push_word(d);
               exp_q.push_back({18'((base_i + pushed) % ADDR_SPAN), d});
               pushed = pushed + 1;
            end
            enable = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            k = k + 1;
         end
         enable = 1'b1;
         wait_idle(1000);
         enable = 1'b0;
         compare_writes();
         check("rand_words", 64'(words_written), 64'(n));
         check("rand_addr", 64'(bus.sram_addr), 64'((base_i + n) % ADDR_SPAN));
         check("rand_wraps", 64'(wrap_cnt - s_wrap), 64'((base_i + n >= ADDR_SPAN) ? 1 : 0));
         check_counts(n);
      end

`ifdef SRAM_VERIFY_EN
      // Read-back mismatch at base+1 sets a sticky error until the next start.
      corrupt_addr = 18'h00501;
      for (int j = 0; j < 3; j++) begin
         push_word(16'h1230 + 16'(j));
         exp_q.push_back({18'h00500 + 18'(j), 16'h1230 + 16'(j)});
      end
      base_addr = 18'h00500;
      start = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_word2_write(200);
      check("verr_before", 64'(verify_err), 64'(0));
      k = 0;
      while (words_written != 16'd2 && k < 100) begin
         @(negedge clk);
         k = k + 1;
      end
      check("verr_word2", 64'(verify_err), 64'(1));
      wait_idle(200);
      check("verr_sticky", 64'(verify_err), 64'(1));
      enable = 1'b0;
      compare_writes();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("verr_cleared", 64'(verify_err), 64'(0));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_sram_writer.md
Name: fifo_sram_writer

Overview:
- Single-clock drain stage that sits directly downstream of the 16-bit FIFO.
- Pops one word at a time from the FIFO and writes it to asynchronous SRAM at an incrementing address.
- Generates the SRAM strobes: ce_n, we_n, oe_n, plus the data-bus drive enable.
- Converts the FIFO's read-side handshake into timed SRAM write cycles for the rest of the SRAM controller.

Parameters:
- DATA_W, 16, FIFO and SRAM data width.
- ADDR_W, 18, SRAM word-address width.
- WE_CYCLES, 2, clocks that sram_we_n is held low per write; legal range 1 to 15.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  while high, drain the FIFO whenever it is non-empty.
- start  input  1  one-clock pulse; loads base_addr into the address pointer and clears counters.
- base_addr  input  ADDR_W  start address sampled on start.
- fifo_data  input  DATA_W  FIFO output_data.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read_enable; one-clock pulse per pop.
- sram_addr  output  ADDR_W  SRAM address.
- sram_dq_out  output  DATA_W  write data to the top-level tristate.
- sram_dq_oe  output  1  high = drive sram_dq_out onto the bus.
- sram_ce_n  output  1  chip enable, active low.
- sram_we_n  output  1  write enable, active low.
- sram_oe_n  output  1  output enable, active low.
- busy  output  1  high whenever state is not IDLE.
- words_written  output  16  count of completed writes since start; wraps at 65535 to 0.
- addr_wrap  output  1  one-clock pulse when the pointer rolls from all-ones to 0.

Behaviour:
- Reset values:
  - state IDLE.
  - fifo_rd_en=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - sram_ce_n=1, sram_we_n=1, sram_oe_n=1.
  - busy=0, words_written=0, addr_wrap=0.
- Reset is asynchronous: it forces all strobes inactive immediately, even mid-write; the in-flight word is lost.
- FIFO read latency: fifo_data is valid in the clock after the fifo_rd_en pulse.
- start:
  - Honoured only in IDLE; ignored while busy.
  - When start and the pop condition coincide in IDLE, the load happens first, so the first write goes to base_addr.
- State machine; all outputs registered:
  - IDLE: if enable=1 and fifo_empty=0, go to POP.
  - POP: fifo_rd_en=1 for exactly this clock -> LATCH.
  - LATCH: capture fifo_data into the data register -> SETUP.
  - SETUP: sram_ce_n=0, sram_dq_oe=0->1, address and data stable, sram_we_n=1 -> WRITE.
  - WRITE: sram_we_n=0 for WE_CYCLES clocks, address and data unchanged -> HOLD.
  - HOLD: sram_we_n=1, data still driven for 1 clock. Then:
    - increment sram_addr modulo 2^ADDR_W;
    - increment words_written;
    - deassert ce_n/dq_oe;
    - if enable=1 and fifo_empty=0, go to POP, else IDLE.
- Per-word cost is 4+WE_CYCLES clocks (6 at default).
- Address and data never change while sram_we_n=0.
- sram_oe_n stays 1 in all write states.
- enable falling mid-word: the current word completes, then the block returns to IDLE.
- fifo_rd_en is never asserted while fifo_empty=1; empty is sampled only in IDLE and HOLD.
- Wrap: when the increment takes sram_addr from 2^ADDR_W-1 to 0, addr_wrap pulses high for the HOLD-exit clock.

Optional Feature:
- Macro: SRAM_VERIFY_EN.
- Defined:
  - Adds input sram_dq_in (DATA_W) and output verify_err (1).
  - After HOLD, a VERIFY state runs for 2 clocks with sram_ce_n=0, sram_oe_n=0, sram_dq_oe=0, at the same address.
  - On the 2nd clock sram_dq_in is compared with the latched data; a mismatch sets verify_err.
  - verify_err is sticky; cleared by reset or an honoured start.
  - The address increments on VERIFY exit, not on HOLD exit. Per-word cost becomes 6+WE_CYCLES.
- Undefined: the VERIFY state and both extra ports are absent; timing is as above.

Test Plan:
- Reset, then start with base_addr=0x00100 and FIFO preloaded with 0x0100..0x010F (16 words), enable=1 -> 16 writes to 0x00100..0x0010F with matching data; fifo_rd_en pulses exactly 16 times; words_written=16; busy falls 1 clock after the last HOLD; total 96 clocks.
- FIFO empty with enable=1 -> no fifo_rd_en; all strobes stay high; busy=0.
- base_addr=0x3FFFE, 3 words -> writes to 0x3FFFE, 0x3FFFF, 0x00000; addr_wrap pulses once, after the 2nd word.
- Drop enable during WRITE of word 2 of 5 -> word 2 completes; words_written=2; remaining 3 words stay in the FIFO; re-enable resumes at base+2.
- Assert rst_n=0 while sram_we_n=0 -> sram_we_n, sram_ce_n and sram_dq_oe go inactive the same instant (no clock edge needed); words_written=0.
- SRAM_VERIFY_EN defined, SRAM model corrupts address base+1 -> verify_err rises during word 2's VERIFY and stays 1 through word 3; next start clears it.
